pll_phase_shift_ctrl: RTL and testbench

PLL_PHASE_SHIFT_CTRL -- requirements
Module: pll_phase_shift_ctrl

---
 rtl/pll_phase_shift_pkg.sv | 32 +++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_phase_shift_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pll_phase_shift_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_shift_pkg.sv
// Shared types and constants for the PLL phase-shift controller.
package pll_phase_shift_pkg;

  // Controller states; the encoding is exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ROT_HI    = 3'd2,
    ST_ROT_GAP   = 3'd3,
    ST_LOAD      = 3'd4,
    ST_WAIT_LOCK = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  // Bit positions inside the 3-bit output-select request.
  localparam int SEL_OUT0 = 0;
  localparam int SEL_OUT2 = 1;
  localparam int SEL_OUT3 = 2;

  // Default timing parameters.
  localparam int STEP_GAP_DEF     = 4;
  localparam int LOAD_CYCLES_DEF  = 2;
  localparam int LOCK_TIMEOUT_DEF = 1023;

  // Largest of three values, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk_i domain.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw lock through two flops; both clear to "not locked" on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_phase_shift_ctrl.sv
// PLL dynamic phase-shift controller: accepts one request at a time, emits the
// requested number of PHASE_ROTATE pulses on the selected outputs, strobes
// LOAD_PHASE_N, then waits (bounded) for the PLL to re-lock.
//
// Handshake: a request transfers on a clock edge where req_valid_i and
// req_ready_o are both 1; sel/dir/steps are captured on that edge. ready is
// only ever 1 in IDLE, and inputs presented while busy are ignored entirely.
module pll_phase_shift_ctrl
  import pll_phase_shift_pkg::*;
#(
  parameter int STEP_GAP     = STEP_GAP_DEF,
  parameter int LOAD_CYCLES  = LOAD_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] req_sel_i,
  input  logic       req_dir_i,
  input  logic [7:0] req_steps_i,
  input  logic       pll_lock_i,
  output logic       phase_out0_sel_o,
  output logic       phase_out2_sel_o,
  output logic       phase_out3_sel_o,
  output logic       phase_direction_o,
  output logic       phase_rotate_o,
  output logic       load_phase_n_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] dbg_state_o
);

  // One down-counter serves the step gap, the load width and the lock timeout.
  localparam int TMR_MAX = max3(STEP_GAP, LOAD_CYCLES, LOCK_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(STEP_GAP - 1);
  localparam logic [TMR_W-1:0] LOAD_LD = TMR_W'(LOAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       steps_q, steps_d;
  logic [2:0]       cap_sel_q, cap_sel_d;
  logic             cap_dir_q, cap_dir_d;
  logic             err_flag_q, err_flag_d;

  // Registered outputs.
  logic       ready_q, ready_d;
  logic [2:0] sel_q, sel_d;
  logic       dir_q, dir_d;
  logic       rot_q, rot_d;
  logic       load_n_q, load_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic lock_sync;
  logic accept;
  logic drive_sel;

  pll_lock_sync u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (reset_n_i),
    .async_i(pll_lock_i),
    .sync_o (lock_sync)
  );

  // ready_q is the only flop whose next value differs from its reset value
  // while idle, so it doubles as the reset-release synchronizer: nothing can
  // leave IDLE until ready_q has cleanly risen on the first edge after reset.
  assign accept = req_valid_i && ready_q;

  // Next-state, capture and timer logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    steps_d    = steps_q;
    cap_sel_d  = cap_sel_q;
    cap_dir_d  = cap_dir_q;
    err_flag_d = err_flag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap_sel_d = req_sel_i;
          cap_dir_d = req_dir_i;
          steps_d   = req_steps_i;
          if (req_sel_i == 3'b000) begin
            state_d    = ST_FINISH;
            err_flag_d = 1'b1;
          end else if (req_steps_i == 8'd0) begin
            state_d    = ST_FINISH;
            err_flag_d = 1'b0;
          end else begin
            state_d    = ST_SETUP;
            err_flag_d = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ROT_HI;
      end
      ST_ROT_HI: begin
        steps_d = steps_q - 8'd1;
        timer_d = GAP_LD;
        state_d = ST_ROT_GAP;
      end
      ST_ROT_GAP: begin
        if (timer_q == '0) begin
          if (steps_q != 8'd0) begin
            state_d = ST_ROT_HI;
          end else begin
            state_d = ST_LOAD;
            timer_d = LOAD_LD;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_LOAD: begin
        if (timer_q == '0) begin
          state_d = ST_WAIT_LOCK;
          timer_d = LOCK_LD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen in the last timeout cycle still counts as success.
        if (lock_sync) begin
          state_d    = ST_FINISH;
          err_flag_d = 1'b0;
        end else if (timer_q == '0) begin
          state_d    = ST_FINISH;
          err_flag_d = 1'b1;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    drive_sel = (state_d == ST_SETUP) || (state_d == ST_ROT_HI) ||
                (state_d == ST_ROT_GAP) || (state_d == ST_LOAD);
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    sel_d     = drive_sel ? cap_sel_d : 3'b000;
    dir_d     = drive_sel ? cap_dir_d : 1'b0;
    rot_d     = (state_d == ST_ROT_HI);
    load_n_d  = (state_d != ST_LOAD);
    done_d    = (state_d == ST_FINISH);
    err_d     = (state_d == ST_FINISH) && err_flag_d;
  end

  // State, datapath and output registers; reset aborts any operation silently.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      steps_q    <= 8'd0;
      cap_sel_q  <= 3'b000;
      cap_dir_q  <= 1'b0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b0;
      sel_q      <= 3'b000;
      dir_q      <= 1'b0;
      rot_q      <= 1'b0;
      load_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      steps_q    <= steps_d;
      cap_sel_q  <= cap_sel_d;
      cap_dir_q  <= cap_dir_d;
      err_flag_q <= err_flag_d;
      ready_q    <= ready_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      rot_q      <= rot_d;
      load_n_q   <= load_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o       = ready_q;
  assign phase_out0_sel_o  = sel_q[SEL_OUT0];
  assign phase_out2_sel_o  = sel_q[SEL_OUT2];
  assign phase_out3_sel_o  = sel_q[SEL_OUT3];
  assign phase_direction_o = dir_q;
  assign phase_rotate_o    = rot_q;
  assign load_phase_n_o    = load_n_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_pll_phase_shift_ctrl.sv
// Self-checking bench for pll_phase_shift_ctrl. Expected traces come from a
// timeline model: pulse k at accept+2+k*(gap+1), load after the last gap,
// then lock wait bounded by the timeout.
module tb_pll_phase_shift_ctrl;

  localparam int G  = 4;     // step gap
  localparam int LC = 2;     // load width
  localparam int LT = 1023;  // lock timeout
  localparam int NEVER = 1000000;
  localparam logic [9:0] RESET_VEC = 10'b0000010000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_dir = 1'b0;
  logic       pll_lock = 1'b1;
  logic [2:0] req_sel = 3'b000;
  logic [7:0] req_steps = 8'd0;

  logic       req_ready, out0, out2, out3, pdir, prot, load_n, busy, done, err;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pll_phase_shift_ctrl dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_sel_i        (req_sel),
    .req_dir_i        (req_dir),
    .req_steps_i      (req_steps),
    .pll_lock_i       (pll_lock),
    .phase_out0_sel_o (out0),
    .phase_out2_sel_o (out2),
    .phase_out3_sel_o (out3),
    .phase_direction_o(pdir),
    .phase_rotate_o   (prot),
    .load_phase_n_o   (load_n),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .dbg_state_o      (dbg_state)
  );

  // Observed output vector: {ready,busy,done,err,rotate,load_n,dir,sel3,sel2,sel0}.
  function automatic logic [9:0] obs();
    return {req_ready, busy, done, err, prot, load_n, pdir, out3, out2, out0};
  endfunction

  // Raw lock driven during relative cycle r (held high outside [lo,hi]).
  function automatic logic raw_lock(input int r, input int lo, input int hi);
    return !(r >= lo && r <= hi);
  endfunction

  // Relative cycle of the DONE pulse and whether ERR accompanies it.
  function automatic void plan(input logic [2:0] sel, input logic [7:0] steps,
                               input int lo, input int hi,
                               output int dr, output bit err_end);
    if (sel == 3'b000) begin
      dr = 1; err_end = 1'b1;
    end else if (steps == 8'd0) begin
      dr = 1; err_end = 1'b0;
    end else begin
      int w;
      w = 2 + int'(steps) * (G + 1) + LC;
      dr = w + LT; err_end = 1'b1;
      // Lock reaches the controller two cycles after it is driven.
      for (int c = w; c < w + LT; c++) begin
        if (raw_lock(c - 2, lo, hi)) begin
          dr = c + 1; err_end = 1'b0;
          break;
        end
      end
    end
  endfunction

  // Expected output vector at relative cycle r (r=0 is the accept cycle).
  function automatic logic [9:0] model(input int r, input logic [2:0] sel, input logic dir,
                                       input logic [7:0] steps, input int dr, input bit err_end);
    bit   short_op;
    int   l0, w;
    logic rot, ld, act;
    short_op = (sel == 3'b000) || (steps == 8'd0);
    l0 = 2 + int'(steps) * (G + 1);
    w  = l0 + LC;
    rot = 1'b0; ld = 1'b1; act = 1'b0;
    if (!short_op) begin
      rot = (r >= 2) && (r < l0) && (((r - 2) % (G + 1)) == 0);
      ld  = !((r >= l0) && (r < w));
      act = (r >= 1) && (r < w);
    end
    return {r > dr, r <= dr, r == dr, (r == dr) && err_end, rot, ld, act & dir,
            act ? sel : 3'b000};
  endfunction

  // Drive one request and compare every cycle until ready returns.
  task automatic run_op(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                        input int lo, input int hi, input bit chain, input bit hold,
                        output int n_rot, output int n_load, output int done_meas,
                        output logic err_meas);
    int dr;
    bit err_end;
    logic [9:0] a, e;
    if (!chain) begin
      int k;
      k = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    plan(sel, steps, lo, hi, dr, err_end);
    req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
    pll_lock = raw_lock(0, lo, hi);
    n_rot = 0; n_load = 0; done_meas = -1; err_meas = 1'b0;
    for (int r = 1; r <= dr + 1; r++) begin
      @(negedge clk);
      a = obs();
      e = model(r, sel, dir, steps, dr, err_end);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL op_trace rel=%0d sel=%b steps=%0d: got %b want %b", r, sel, steps, a, e);
      end
      if (prot === 1'b1) n_rot++;
      if (load_n === 1'b0) n_load++;
      if (done === 1'b1 && done_meas < 0) begin
        done_meas = r; err_meas = err;
      end
      if (hold && r <= dr) begin
        req_sel = 3'($urandom); req_dir = 1'($urandom); req_steps = 8'($urandom);
      end else if (!hold) begin
        req_valid = 1'b0;
      end
      pll_lock = raw_lock(r, lo, hi);
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== RESET_VEC) begin
      n_mis++;
      $display("FAIL reset_values: got %b want %b", obs(), RESET_VEC);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL ready_before_edge: got %b want 0", req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL ready_first_edge: got %b want 1", req_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    int nr, nl, dm; logic em;
    run_op(3'b001, 1'b1, 8'd3, -1, -2, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 3 || nl != 2 || dm != 20 || em !== 1'b0) begin
      n_mis++;
      $display("FAIL basic_summary: got rot=%0d load=%0d done_rel=%0d err=%b want 3 2 20 0", nr, nl, dm, em);
    end
  endtask

  task automatic test_timeout;
    int nr, nl, dm; logic em;
    // Lock dropped at the start of LOAD (rel 7); WAIT_LOCK entered at rel 9.
    run_op(3'b110, 1'b0, 8'd1, 7, NEVER, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 1 || dm != 9 + 1023 || em !== 1'b1) begin
      n_mis++;
      $display("FAIL timeout_summary: got rot=%0d done_rel=%0d err=%b want 1 1032 1", nr, dm, em);
    end
  endtask

  task automatic test_sel_zero;
    int nr, nl, dm; logic em;
    run_op(3'b000, 1'b1, 8'd5, -1, -2, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 0 || nl != 0 || dm != 1 || em !== 1'b1) begin
      n_mis++;
      $display("FAIL sel_zero_summary: got rot=%0d load=%0d done_rel=%0d err=%b want 0 0 1 1", nr, nl, dm, em);
    end
  endtask

  task automatic test_steps_zero;
    int nr, nl, dm; logic em;
    run_op(3'b101, 1'b1, 8'd0, -1, -2, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 0 || nl != 0 || dm != 1 || em !== 1'b0) begin
      n_mis++;
      $display("FAIL steps_zero_summary: got rot=%0d load=%0d done_rel=%0d err=%b want 0 0 1 0", nr, nl, dm, em);
    end
  endtask

  task automatic test_long;
    int nr, nl, dm; logic em;
    run_op(3'b111, 1'b1, 8'd255, 100, 106, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 255 || em !== 1'b0 || dm != 2 + 255 * 5 + 2 + 1) begin
      n_mis++;
      $display("FAIL long_summary: got rot=%0d done_rel=%0d err=%b want 255 1280 0", nr, dm, em);
    end
  endtask

  task automatic test_reset_mid;
    int k, done_cnt;
    int nr, nl, dm; logic em;
    k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    req_sel = 3'b101; req_dir = 1'b0; req_steps = 8'd4; req_valid = 1'b1;
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_cmp++;
    if (prot !== 1'b1) begin
      n_mis++;
      $display("FAIL second_pulse: got %b want 1", prot);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== RESET_VEC) begin
      n_mis++;
      $display("FAIL reset_mid_values: got %b want %b", obs(), RESET_VEC);
    end
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || prot === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_mis++;
      $display("FAIL reset_mid_quiet: got %0d done/rotate cycles want 0", done_cnt);
    end
    run_op(3'b010, 1'b1, 8'd2, -1, -2, 1'b0, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 2 || dm != 15 || em !== 1'b0) begin
      n_mis++;
      $display("FAIL after_reset_summary: got rot=%0d done_rel=%0d err=%b want 2 15 0", nr, dm, em);
    end
  endtask

  task automatic test_back_to_back;
    int nr, nl, dm; logic em;
    // First request keeps valid high with scrambled fields while busy.
    run_op(3'b011, 1'b1, 8'd2, -1, -2, 1'b0, 1'b1, nr, nl, dm, em);
    n_cmp++;
    if (nr != 2 || dm != 15) begin
      n_mis++;
      $display("FAIL hold_first_summary: got rot=%0d done_rel=%0d want 2 15", nr, dm);
    end
    run_op(3'b100, 1'b0, 8'd1, -1, -2, 1'b1, 1'b0, nr, nl, dm, em);
    n_cmp++;
    if (nr != 1 || dm != 10) begin
      n_mis++;
      $display("FAIL hold_second_summary: got rot=%0d done_rel=%0d want 1 10", nr, dm);
    end
  endtask

  task automatic test_random;
    int nr, nl, dm; logic em;
    int lo, hi;
    logic [2:0] sel;
    logic [7:0] steps;
    for (int i = 0; i < 10; i++) begin
      sel   = 3'($urandom_range(0, 7));
      steps = 8'($urandom_range(0, 12));
      lo    = $urandom_range(0, 40);
      hi    = lo + $urandom_range(0, 6);
      if (i == 4) begin
        lo = 0; hi = NEVER;
      end
      run_op(sel, 1'($urandom), steps, lo, hi, 1'b0, 1'b0, nr, nl, dm, em);
      n_cmp++;
      if (nr != ((sel == 3'b000) ? 0 : int'(steps))) begin
        n_mis++;
        $display("FAIL random_pulse_count: got %0d want %0d", nr, (sel == 3'b000) ? 0 : int'(steps));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_sel_zero;
    test_steps_zero;
    test_long;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
